rank_match_scheduler: RTL and testbench

- Sequences one captured corner-mask buffer against a bank of binary rank kernels, one kernel at a time.
- Drives shared read addresses and the kernel select, and counts XOR mismatches per kernel.
- Tracks the minimum-mismatch kernel and reports the winning index and its score.
- Sits between the corner-capture logic (mask buffer write side) and the card-identification output stage.

---
 rtl/rank_match_pkg.sv | 35 +++
 rtl/xor_score_accum.sv | 50 +++++
 rtl/rank_match_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_rank_match_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_match_pkg.sv
// Shared types and constants for the rank/suit template matcher.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rank_match_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Geometry of the captured card corner and the rank template bank
    localparam int CORNER_WIDTH = 28;
    localparam int RANK_HEIGHT  = 40;
    localparam int RANK_SIZE    = CORNER_WIDTH * RANK_HEIGHT;
    localparam int NUM_RANKS    = 13;
    localparam int SUIT_SIZE    = 812;

    // Kernel index 0..12 maps to A,2..9,T,J,Q,K; leftmost character is index 0
    localparam logic [8*NUM_RANKS-1:0] RANK_ASCII = "A23456789TJQK";

    // ASCII glyph for a winning kernel index, '?' when out of range
    function automatic logic [7:0] rank_to_ascii(input logic [3:0] idx);
        logic [7:0] ch;
        ch = "?";
        if (int'(idx) < NUM_RANKS) begin
            ch = 8'(RANK_ASCII >> (8 * (NUM_RANKS - 1 - int'(idx))));
        end
        return ch;
    endfunction

endpackage

// File: rtl/xor_score_accum.sv
// Counts XOR mismatches between two returned bit streams (rank or suit matching).
// Latency: a valid issued now is accumulated LATENCY cycles later; score visible the cycle after.
// Backpressure: none; acc_en masks in-flight returns, clr empties the score.
module xor_score_accum #(
    parameter int LATENCY = 2,
    parameter int SIZE    = 1120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic                       acc_en,
    input  logic                       clr,
    input  logic                       a_bit,
    input  logic                       b_bit,
    output logic [$clog2(SIZE+1)-1:0]  score
);

    localparam int CW = $clog2(SIZE + 1);

    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CW-1:0]      score_q, score_d;
    logic               ret_vld;

    assign ret_vld = vld_pipe_q[LATENCY-1];
    assign score   = score_q;

    // Shift the issue valid towards the data return and count mismatches
    always_comb begin
        vld_pipe_d = (vld_pipe_q << 1) | LATENCY'(in_vld);
        score_d    = score_q;
        if (clr) begin
            score_d = '0;
        end else if (acc_en && ret_vld && ((a_bit ^ b_bit) == 1'b1)
                     && (score_q != CW'(SIZE))) begin
            score_d = score_q + CW'(1);
        end
    end

    // Pipe and score registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            score_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            score_q    <= score_d;
        end
    end

endmodule

// File: rtl/rank_match_scheduler.sv
// Walks one corner mask against every rank kernel and reports the lowest-mismatch index.
// Latency: NUM_KERNELS*(KERNEL_SIZE+READ_LATENCY+1)+1 cycles from start accept to result_valid.
// Backpressure: none; start is ignored while busy. RANK_MATCH_EARLY_ABORT_EN enables early kernel abort.
module rank_match_scheduler
    import rank_match_pkg::*;
#(
    parameter int NUM_KERNELS  = NUM_RANKS,
    parameter int KERNEL_SIZE  = RANK_SIZE,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic [$clog2(KERNEL_SIZE)-1:0]    rd_addr,
    output logic [$clog2(NUM_KERNELS)-1:0]    kernel_sel,
    input  logic                              kernel_bit,
    input  logic                              mask_bit,
    output logic                              result_valid,
    output logic [$clog2(NUM_KERNELS)-1:0]    best_idx,
    output logic [$clog2(KERNEL_SIZE+1)-1:0]  best_score
);

    localparam int AW = $clog2(KERNEL_SIZE);
    localparam int SW = $clog2(NUM_KERNELS);
    localparam int CW = $clog2(KERNEL_SIZE + 1);
    localparam int DW = $clog2(READ_LATENCY + 1);

    localparam logic [AW-1:0] LAST_ADDR   = AW'(KERNEL_SIZE - 1);
    localparam logic [SW-1:0] LAST_KERNEL = SW'(NUM_KERNELS - 1);
    localparam logic [DW-1:0] LAST_DRAIN  = DW'(READ_LATENCY - 1);

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           result_valid_q, result_valid_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic [SW-1:0]  kernel_sel_q, kernel_sel_d;
    logic [SW-1:0]  best_idx_q, best_idx_d;
    logic [CW-1:0]  best_score_q, best_score_d;
    logic [CW-1:0]  run_best_q, run_best_d;
    logic [SW-1:0]  run_idx_q, run_idx_d;
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;

    logic           issue_vld;
    logic           score_clr;
    logic           acc_en;
    logic           loser;
    logic [CW-1:0]  score;

`ifdef RANK_MATCH_EARLY_ABORT_EN
    // Set once the running score can no longer beat the best; the kernel is
    // then a guaranteed loser and its in-flight returns are discarded.
    logic           abort_q, abort_d;
    assign acc_en = ~abort_q;
    assign loser  = abort_q;
`else
    assign acc_en = 1'b1;
    assign loser  = 1'b0;
`endif

    assign busy         = busy_q;
    assign rd_addr      = rd_addr_q;
    assign kernel_sel   = kernel_sel_q;
    assign result_valid = result_valid_q;
    assign best_idx     = best_idx_q;
    assign best_score   = best_score_q;

    xor_score_accum #(
        .LATENCY (READ_LATENCY),
        .SIZE    (KERNEL_SIZE)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .in_vld (issue_vld),
        .acc_en (acc_en),
        .clr    (score_clr),
        .a_bit  (kernel_bit),
        .b_bit  (mask_bit),
        .score  (score)
    );

    // Next-state and output decode for the kernel sweep
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        rd_addr_d      = rd_addr_q;
        kernel_sel_d   = kernel_sel_q;
        best_idx_d     = best_idx_q;
        best_score_d   = best_score_q;
        run_best_d     = run_best_q;
        run_idx_d      = run_idx_q;
        drain_cnt_d    = drain_cnt_q;
        issue_vld      = 1'b0;
        score_clr      = 1'b0;
`ifdef RANK_MATCH_EARLY_ABORT_EN
        abort_d        = abort_q;
`endif
        case (state_q)
            IDLE: begin
                score_clr    = 1'b1;
                run_best_d   = '1;
                kernel_sel_d = '0;
                rd_addr_d    = '0;
`ifdef RANK_MATCH_EARLY_ABORT_EN
                abort_d      = 1'b0;
`endif
                if (start) begin
                    state_d = ISSUE;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
`ifdef RANK_MATCH_EARLY_ABORT_EN
                if (score >= run_best_q) begin
                    abort_d     = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else
`endif
                begin
                    issue_vld = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = COMPARE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            COMPARE: begin
                score_clr = 1'b1;
                // Strict less-than keeps the earlier (lower) index on ties
                if (!loser && (score < run_best_q)) begin
                    run_best_d = score;
                    run_idx_d  = kernel_sel_q;
                end
`ifdef RANK_MATCH_EARLY_ABORT_EN
                abort_d = 1'b0;
`endif
                if (kernel_sel_q == LAST_KERNEL) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    best_idx_d     = run_idx_d;
                    best_score_d   = run_best_d;
                end else begin
                    kernel_sel_d = kernel_sel_q + SW'(1);
                    rd_addr_d    = '0;
                    state_d      = ISSUE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            rd_addr_q      <= '0;
            kernel_sel_q   <= '0;
            best_idx_q     <= '0;
            best_score_q   <= '0;
            run_best_q     <= '1;
            run_idx_q      <= '0;
            drain_cnt_q    <= '0;
`ifdef RANK_MATCH_EARLY_ABORT_EN
            abort_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            rd_addr_q      <= rd_addr_d;
            kernel_sel_q   <= kernel_sel_d;
            best_idx_q     <= best_idx_d;
            best_score_q   <= best_score_d;
            run_best_q     <= run_best_d;
            run_idx_q      <= run_idx_d;
            drain_cnt_q    <= drain_cnt_d;
`ifdef RANK_MATCH_EARLY_ABORT_EN
            abort_q        <= abort_d;
`endif
        end
    end

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Scoreboard bench for rank_match_scheduler with a small kernel bank and emulated memories.
// Latency: expects the fixed sweep latency (bounded above by it in the early-abort build).
// Backpressure: none; start pulses during a pass must be ignored.
module tb_rank_match_scheduler;

    localparam int NK = 4;
    localparam int KS = 16;
    localparam int RL = 2;
    localparam int AW = $clog2(KS);
    localparam int SW = $clog2(NK);
    localparam int CW = $clog2(KS + 1);
    localparam int FIXED_LAT = NK * (KS + RL + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] kernel_sel;
    logic          kernel_bit;
    logic          mask_bit;
    logic          result_valid;
    logic [SW-1:0] best_idx;
    logic [CW-1:0] best_score;

    typedef struct {
        int idx;
        int score;
        int start_cyc;
        bit early;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_lat;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    logic [KS-1:0] kmem [NK];
    logic [KS-1:0] mask_v;
    logic [AW-1:0] a1, a2;
    logic [SW-1:0] s1, s2;

    always #5 clk = ~clk;

    rank_match_scheduler #(
        .NUM_KERNELS  (NK),
        .KERNEL_SIZE  (KS),
        .READ_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .rd_addr      (rd_addr),
        .kernel_sel   (kernel_sel),
        .kernel_bit   (kernel_bit),
        .mask_bit     (mask_bit),
        .result_valid (result_valid),
        .best_idx     (best_idx),
        .best_score   (best_score)
    );

    // Two-cycle read memories: kernel bank and corner mask buffer
    always @(posedge clk) begin
        cyc <= cyc + 1;
        a1  <= rd_addr;
        s1  <= kernel_sel;
        a2  <= a1;
        s2  <= s1;
    end
    assign kernel_bit = kmem[s2][a2];
    assign mask_bit   = mask_v[a2];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: result_valid=1 at cycle %0d, expected no result", cyc);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_lat = cyc - mon_e.start_cyc;
                    check("best_idx", int'(best_idx), mon_e.idx);
                    check("best_score", int'(best_score), mon_e.score);
                    check("busy_cycles", busy_cnt, mon_lat);
`ifdef RANK_MATCH_EARLY_ABORT_EN
                    tests++;
                    if (mon_lat > FIXED_LAT || (mon_e.early && mon_lat >= FIXED_LAT)) begin
                        fails++;
                        $display("FAIL latency_abort: got %0d, expected <= %0d (strictly less when early=%0d)",
                                 mon_lat, FIXED_LAT, mon_e.early);
                    end
`else
                    check("latency", mon_lat, FIXED_LAT);
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    // Random bit pattern with exactly n ones
    function automatic logic [KS-1:0] ones_pattern(input int n);
        logic [KS-1:0] v;
        logic          t;
        int            j;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        for (int i = KS - 1; i > 0; i--) begin
            j    = $urandom_range(i, 0);
            t    = v[i];
            v[i] = v[j];
            v[j] = t;
        end
        return v;
    endfunction

    task automatic set_bank(input int d0, input int d1, input int d2, input int d3);
        mask_v  = KS'($urandom);
        kmem[0] = mask_v ^ ones_pattern(d0);
        kmem[1] = mask_v ^ ones_pattern(d1);
        kmem[2] = mask_v ^ ones_pattern(d2);
        kmem[3] = mask_v ^ ones_pattern(d3);
    endtask

    // Reference: popcount of differences, first minimum wins; called at a negedge
    task automatic issue_start(input bit early);
        exp_t e;
        int   best;
        int   s;
        best  = KS + 1;
        e.idx = 0;
        for (int k = 0; k < NK; k++) begin
            s = $countones(kmem[k] ^ mask_v);
            if (s < best) begin
                best  = s;
                e.idx = k;
            end
        end
        e.score     = best;
        e.start_cyc = cyc;
        e.early     = early;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_result_valid"}, int'(result_valid), 0);
        check({name, "_rd_addr"}, int'(rd_addr), 0);
        check({name, "_kernel_sel"}, int'(kernel_sel), 0);
        check({name, "_best_idx"}, int'(best_idx), 0);
        check({name, "_best_score"}, int'(best_score), 0);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        mask_v = '0;
        for (int k = 0; k < NK; k++) kmem[k] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Distinct scores, winner in the middle
        set_bank(9, 3, 7, 12);
        issue_start(1'b0);
        wait_idle("scores_9_3_7_12");

        // Tie between kernels 0 and 2
        set_bank(5, 10, 5, 10);
        issue_start(1'b0);
        wait_idle("tie");

        // Exact match on the last kernel
        set_bank(4, 6, 8, 0);
        issue_start(1'b0);
        wait_idle("exact_k3");

        // Every bit mismatches on every kernel
        mask_v = '1;
        for (int k = 0; k < NK; k++) kmem[k] = '0;
        issue_start(1'b0);
        wait_idle("all_mismatch");

        // start re-pulsed mid-pass must be ignored
        set_bank(11, 2, 14, 2);
        issue_start(1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("repulse");

        // start during DONE ignored, start the following cycle accepted
        set_bank(8, 8, 1, 6);
        issue_start(1'b0);
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(result_valid), 1);
        start = 1'b1;
        @(negedge clk);
        issue_start(1'b0);
        wait_idle("back_to_back");

        // Reset mid-pass aborts the pass
        set_bank(7, 7, 7, 2);
        issue_start(1'b0);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_reset_busy_after", int'(busy), 0);
        set_bank(6, 13, 3, 9);
        issue_start(1'b0);
        wait_idle("after_reset");

        // Early winner, later kernels clearly worse
        set_bank(3, 9, 9, 9);
        issue_start(1'b1);
        wait_idle("early_winner");

        // Randomized banks
        for (int p = 0; p < 10; p++) begin
            set_bank($urandom_range(KS, 0), $urandom_range(KS, 0),
                     $urandom_range(KS, 0), $urandom_range(KS, 0));
            issue_start(1'b0);
            wait_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Backstop against a stuck bench
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
